vector_data_mem_responder: RTL and testbench

//   Memory-side responder for the MEM-stage data-memory interface. Accepts one

---
 rtl/vector_data_mem_responder.sv | 107 ++++++++++
 tb/tb_vector_data_mem_responder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vector_data_mem_responder.sv
// vector_data_mem_responder: MEM-stage data-memory responder serving scalar or I-lane vector loads/stores, one lane per cycle
// Ports: CLK/RST (async, active-low) | req_i, op_type_i (1=vector), we_i (1=store), addr_i, wdata_s_i, wdata_v_i
//        -> busy_o, finished_o (one-cycle done pulse), rdata_s_o, rdata_v_o, error_o
// Option: DATA_MEM_BOUNDS_CHECK_EN makes out-of-range vector requests skip RAM and pulse error_o instead of wrapping.
module vector_data_mem_responder #(
    parameter int I  = 2,
    parameter int L  = 8,
    parameter int AW = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           req_i,
    input  logic           op_type_i,
    input  logic           we_i,
    input  logic [AW-1:0]  addr_i,
    input  logic [L-1:0]   wdata_s_i,
    input  logic [I*L-1:0] wdata_v_i,
    output logic           busy_o,
    output logic           finished_o,
    output logic [L-1:0]   rdata_s_o,
    output logic [I*L-1:0] rdata_v_o,
    output logic           error_o
);
    localparam int DEPTH = 2**AW;
    localparam int CW = I > 1 ? $clog2(I) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t         state;
    logic           op_q, we_q, oob_q;
    logic [AW-1:0]  addr_q;
    logic [L-1:0]   wdata_s_q;
    logic [I*L-1:0] wdata_v_q;
    logic [CW-1:0]  cnt;
    logic [L-1:0]   mem [DEPTH];
    logic [AW-1:0]  a;
    logic [L-1:0]   lane_wd;
    logic           last, oob, mem_we;

    // Lane address wraps naturally through the AW-bit adder.
    assign a       = addr_q + AW'(cnt);
    assign last    = !op_q || cnt == CW'(I - 1);
    assign lane_wd = op_q ? wdata_v_q[cnt*L +: L] : wdata_s_q;
    assign mem_we  = state == ACCESS && we_q && !oob_q;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    assign oob = op_type_i && ({1'b0, addr_i} + (AW+1)'(I - 1) > (AW+1)'(DEPTH - 1));
`else
    assign oob = 1'b0;
`endif

    // RAM has no reset: contents survive RST.
    always_ff @(posedge CLK)
        if (mem_we) mem[a] <= lane_wd;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            finished_o <= 1'b0;
            error_o    <= 1'b0;
            rdata_s_o  <= '0;
            rdata_v_o  <= '0;
            cnt        <= '0;
            op_q       <= 1'b0;
            we_q       <= 1'b0;
            oob_q      <= 1'b0;
            addr_q     <= '0;
            wdata_s_q  <= '0;
            wdata_v_q  <= '0;
        end else begin
            finished_o <= 1'b0;
            error_o    <= 1'b0;
            case (state)
                // DONE accepts a new request too, giving back-to-back service.
                IDLE, DONE: begin
                    busy_o <= req_i;
                    state  <= req_i ? ACCESS : IDLE;
                    if (req_i) begin
                        op_q      <= op_type_i;
                        we_q      <= we_i;
                        oob_q     <= oob;
                        addr_q    <= addr_i;
                        wdata_s_q <= wdata_s_i;
                        wdata_v_q <= wdata_v_i;
                        cnt       <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q && !oob_q) begin
                        if (op_q) rdata_v_o[cnt*L +: L] <= mem[a];
                        else      rdata_s_o             <= mem[a];
                    end
                    if (last) begin
                        state      <= DONE;
                        busy_o     <= 1'b0;
                        finished_o <= 1'b1;
                        error_o    <= oob_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_data_mem_responder.sv
// tb_vector_data_mem_responder: directed self-checking bench for vector_data_mem_responder
module tb_vector_data_mem_responder;
    logic        CLK = 1'b0, RST = 1'b0;
    logic        req_i = 1'b0, op_type_i = 1'b0, we_i = 1'b0;
    logic [7:0]  addr_i = '0, wdata_s_i = '0;
    logic [15:0] wdata_v_i = '0;
    logic        busy_o, finished_o, error_o;
    logic [7:0]  rdata_s_o;
    logic [15:0] rdata_v_o;
    int          tests = 0, fails = 0;
    logic        err_seen;

    vector_data_mem_responder dut (
        .CLK(CLK), .RST(RST), .req_i(req_i), .op_type_i(op_type_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_s_i(wdata_s_i), .wdata_v_i(wdata_v_i),
        .busy_o(busy_o), .finished_o(finished_o), .rdata_s_o(rdata_s_o),
        .rdata_v_o(rdata_v_o), .error_o(error_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request and follows it to finished_o; cycle 1 is the one after the sampling edge.
    task automatic xact(input string tag, input logic op, input logic we, input logic [7:0] a,
                        input logic [7:0] ws, input logic [15:0] wv, input int lat);
        int n;
        op_type_i = op; we_i = we; addr_i = a; wdata_s_i = ws; wdata_v_i = wv; req_i = 1'b1;
        @(posedge CLK); #1 req_i = 1'b0;
        n = 1;
        check({tag, "_busy1"}, busy_o, 1'b1);
        check({tag, "_fin1"}, finished_o, 1'b0);
        while (!finished_o && n < 20) begin
            @(posedge CLK); #1 n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_busy_done"}, busy_o, 1'b0);
        err_seen = error_o;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_fin", finished_o, 1'b0);
        check("rst_err", error_o, 1'b0);
        check("rst_rs", rdata_s_o, 8'h00);
        check("rst_rv", rdata_v_o, 16'h0000);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Reset in the middle of a vector store, after lane 0 is written.
        xact("pre_st", 1'b0, 1'b1, 8'h31, 8'h5A, 16'h0, 2);
        xact("pre_ld", 1'b0, 1'b0, 8'h31, 8'h00, 16'h0, 2);
        check("pre_rs", rdata_s_o, 8'h5A);
        op_type_i = 1'b1; we_i = 1'b1; addr_i = 8'h30; wdata_v_i = 16'h7766; req_i = 1'b1;
        @(posedge CLK); #1 req_i = 1'b0;
        @(posedge CLK); #1 RST = 1'b0;
        #1;
        check("mid_busy", busy_o, 1'b0);
        check("mid_fin", finished_o, 1'b0);
        check("mid_rs", rdata_s_o, 8'h00);
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        check("mid_idle", busy_o, 1'b0);
        xact("mid_ld0", 1'b0, 1'b0, 8'h30, 8'h00, 16'h0, 2);
        check("mid_lane0", rdata_s_o, 8'h66);
        xact("mid_ld1", 1'b0, 1'b0, 8'h31, 8'h00, 16'h0, 2);
        check("mid_lane1", rdata_s_o, 8'h5A);

        // Scalar store then load.
        xact("s_st", 1'b0, 1'b1, 8'h10, 8'hA5, 16'h0, 2);
        check("s_st_rs", rdata_s_o, 8'h5A);
        xact("s_ld", 1'b0, 1'b0, 8'h10, 8'h00, 16'h0, 2);
        check("s_ld_rs", rdata_s_o, 8'hA5);
        check("s_ld_rv", rdata_v_o, 16'h0000);

        // Vector store then load.
        xact("v_st", 1'b1, 1'b1, 8'h20, 8'h00, 16'h2211, 3);
        xact("v_ld", 1'b1, 1'b0, 8'h20, 8'h00, 16'h0, 3);
        check("v_ld_rv", rdata_v_o, 16'h2211);
        check("v_ld_rs", rdata_s_o, 8'hA5);
        xact("v_ld1", 1'b0, 1'b0, 8'h21, 8'h00, 16'h0, 2);
        check("v_lane1", rdata_s_o, 8'h22);

        // Back-to-back: second call raises req_i during the DONE cycle.
        xact("b2b_st", 1'b1, 1'b1, 8'h40, 8'h00, 16'hBBAA, 3);
        xact("b2b_ld", 1'b1, 1'b0, 8'h40, 8'h00, 16'h0, 3);
        check("b2b_rv", rdata_v_o, 16'hBBAA);

        // Vector store at the top of memory: wraps, or is rejected with bounds checking.
        xact("w_pre0", 1'b0, 1'b1, 8'hFF, 8'hC3, 16'h0, 2);
        xact("w_pre1", 1'b0, 1'b1, 8'h00, 8'h3C, 16'h0, 2);
        xact("w_st", 1'b1, 1'b1, 8'hFF, 8'h00, 16'hE2E1, 3);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        check("w_err", err_seen, 1'b1);
`else
        check("w_err", err_seen, 1'b0);
`endif
        @(posedge CLK); #1;
        check("w_err_pulse", error_o, 1'b0);
        xact("w_ld0", 1'b0, 1'b0, 8'hFF, 8'h00, 16'h0, 2);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        check("w_ff", rdata_s_o, 8'hC3);
`else
        check("w_ff", rdata_s_o, 8'hE1);
`endif
        xact("w_ld1", 1'b0, 1'b0, 8'h00, 8'h00, 16'h0, 2);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        check("w_00", rdata_s_o, 8'h3C);
`else
        check("w_00", rdata_s_o, 8'hE2);
`endif
        check("w_ld_err", err_seen, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
